// File: rtl/m_btb_predictor.sv
// Fully associative branch target buffer with saturating direction counters,
// true-LRU replacement, whole-table flush and update/misprediction statistics.
module m_btb_predictor #(
  parameter int ADDR_W  = 11,
  parameter int ENTRIES = 4,
  parameter int CNT_W   = 2
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic [ADDR_W-1:0] w_paddr,
  output logic              w_pre,
  output logic              w_pr,
  output logic [ADDR_W-1:0] w_ptgt,
  input  logic              w_be,
  input  logic [ADDR_W-1:0] w_baddr,
  input  logic              w_br,
  input  logic [ADDR_W-1:0] w_btgt,
  input  logic              w_flush,
  output logic [15:0]       w_nupd,
  output logic [15:0]       w_nmis
);

  localparam int AGE_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [AGE_W-1:0] AGE_LRU = AGE_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tag_d [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_d [ENTRIES];
  logic [AGE_W-1:0]   age_q [ENTRIES];
  logic [AGE_W-1:0]   age_d [ENTRIES];
  logic [15:0]        nupd_q, nupd_d, nmis_q, nmis_d;

  logic               l_hit, u_hit, v_inv;
  logic [AGE_W-1:0]   l_idx, u_idx, v_inv_idx, v_lru_idx, sel_idx, sel_age;
  logic               u_pred;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec_cnt(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    l_hit     = 1'b0;
    l_idx     = '0;
    u_hit     = 1'b0;
    u_idx     = '0;
    v_inv     = 1'b0;
    v_inv_idx = '0;
    v_lru_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == w_paddr) begin
        l_hit = 1'b1;
        l_idx = AGE_W'(i);
      end
      if (valid_q[i] && tag_q[i] == w_baddr) begin
        u_hit = 1'b1;
        u_idx = AGE_W'(i);
      end
      if (!valid_q[i]) begin
        v_inv     = 1'b1;
        v_inv_idx = AGE_W'(i);
      end
      if (age_q[i] == AGE_LRU) begin
        v_lru_idx = AGE_W'(i);
      end
    end
  end

  assign w_pre  = l_hit;
  assign w_pr   = l_hit & cnt_q[l_idx][CNT_W-1];
  assign w_ptgt = w_pr ? tgt_q[l_idx] : w_paddr + ADDR_W'(1);

  assign sel_idx = u_hit ? u_idx : (v_inv ? v_inv_idx : v_lru_idx);
  assign sel_age = age_q[sel_idx];
  assign u_pred  = u_hit & cnt_q[u_idx][CNT_W-1];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    age_d   = age_q;
    nupd_d  = nupd_q;
    nmis_d  = nmis_q;
    if (w_flush) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) age_d[i] = AGE_W'(i);
    end else if (w_be) begin
      nupd_d = sat_inc16(nupd_q);
      if (u_pred != w_br) nmis_d = sat_inc16(nmis_q);
      if (u_hit) begin
        cnt_d[sel_idx] = w_br ? sat_inc_cnt(cnt_q[sel_idx]) : sat_dec_cnt(cnt_q[sel_idx]);
        if (w_br) tgt_d[sel_idx] = w_btgt;
      end else begin
        valid_d[sel_idx] = 1'b1;
        tag_d[sel_idx]   = w_baddr;
        tgt_d[sel_idx]   = w_btgt;
        cnt_d[sel_idx]   = w_br ? CNT_WT : CNT_WNT;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (age_q[i] < sel_age) age_d[i] = age_q[i] + AGE_W'(1);
      end
      age_d[sel_idx] = '0;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      valid_q <= '0;
      nupd_q  <= '0;
      nmis_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '1;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_WNT;
        age_q[i] <= AGE_W'(i);
      end
    end else begin
      valid_q <= valid_d;
      nupd_q  <= nupd_d;
      nmis_q  <= nmis_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= tag_d[i];
        tgt_q[i] <= tgt_d[i];
        cnt_q[i] <= cnt_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  assign w_nupd = nupd_q;
  assign w_nmis = nmis_q;

endmodule

// File: doc/m_btb_predictor.md
# m_btb_predictor

Parametrised branch target buffer and direction predictor for the five-stage pipeline. It succeeds the 2-entry, 1-bit-history predictor. IF looks up the current PC combinationally and receives a hit flag, a taken prediction and a predicted target. EX writes back each resolved conditional branch. The block adds N-way fully associative storage, saturating direction counters, stored targets, true-LRU replacement, a flush input and statistics counters.

## Interface
- ADDR_W, 11: word-address width of PCs and targets.
- ENTRIES, 4: number of table entries. Must be a power of two in the range 2..16.
- CNT_W, 2: width of the direction counter. Range 1..4.

Ports:
- w_clk  in  1  clock; all state updates on its rising edge.
- w_rst_n  in  1  reset, asynchronous, active-low.
- w_paddr  in  ADDR_W  IF lookup PC.
- w_pre  out  1  lookup hit.
- w_pr  out  1  predicted taken (0 on miss).
- w_ptgt  out  ADDR_W  predicted next PC.
- w_be  in  1  update enable (resolved branch in EX).
- w_baddr  in  ADDR_W  resolved branch PC.
- w_br  in  1  actual outcome (1 = taken).
- w_btgt  in  ADDR_W  actual taken target.
- w_flush  in  1  invalidate whole table.
- w_nupd  out  16  accepted-update count.
- w_nmis  out  16  misprediction count.

## Operation
- **Entry state:** valid, tag[ADDR_W], target[ADDR_W], cnt[CNT_W], age[log2 ENTRIES]. Ages always form a permutation of 0..ENTRIES-1, where 0 is MRU.
- **Lookup (combinational):**
  - Hit when an entry is valid and its tag equals w_paddr. If several entries match, the lowest index wins; allocation prevents duplicates.
  - w_pre = hit.
  - w_pr = hit & cnt[CNT_W-1].
  - w_ptgt = (hit & w_pr) ? target : w_paddr+1, computed modulo 2^ADDR_W.
- **Update (w_be=1, w_flush=0), hit on w_baddr:**
  - cnt saturating +1 if w_br, else saturating -1.
  - If w_br, target <= w_btgt.
  - The entry is touched.
- **Update, miss on w_baddr:**
  - Victim is the lowest-index invalid entry; if none, the entry with age ENTRIES-1.
  - Victim gets valid=1, tag=w_baddr, target=w_btgt.
  - cnt = w_br ? 2^(CNT_W-1) : 2^(CNT_W-1)-1 (weakly taken / weakly not-taken). With CNT_W=1 this gives 1 / 0.
  - The victim is touched.
- **Touch of entry k with age a:** every entry whose age is < a increments; age[k] <= 0.
- **Statistics:**
  - On every accepted update, w_nupd increments.
  - w_nmis increments when the prediction for w_baddr (hit & cnt MSB, 0 on miss) differs from w_br.
  - Both counters saturate at 16'hFFFF.
  - Flush does not clear them.
- **Flush:**
  - All valid <= 0 and age[i] <= i. Tag, target and cnt are untouched.
  - Flush has priority: an update in the same cycle is dropped and not counted.
- **Reset:**
  - valid=0, tag=all ones, target=0, cnt=2^(CNT_W-1)-1, age[i]=i, w_nupd=w_nmis=0.
  - Outputs in reset: w_pre=0, w_pr=0, w_ptgt=w_paddr+1.

## Timing
- Lookup latency is 0 cycles (pure combinational from w_paddr and the registered table).
- An update sampled at edge n is visible to lookups from edge n onward (after the register update).
- There is no bypass: a lookup during the cycle of an update to the same address sees the old state.
- Simultaneous lookup and update on different addresses are independent.
- Reset assertion clears state immediately, without waiting for a clock edge. Deassertion is synchronous-safe; the first update is accepted at the first edge after w_rst_n=1.
- w_nupd and w_nmis are registered and change only on the clock edge.

## Test plan
All scenarios use ADDR_W=11, ENTRIES=4, CNT_W=2.
1. **Reset, empty table:** reset, lookup 0x010 -> w_pre=0, w_pr=0, w_ptgt=0x011, w_nupd=w_nmis=0. Lookup 0x7FF -> w_ptgt=0x000 (wrap).
2. **First allocation:** update baddr=0x010, br=1, btgt=0x020. Next cycle lookup 0x010 -> w_pre=1, w_pr=1 (cnt=2), w_ptgt=0x020, w_nupd=1, w_nmis=1.
3. **Counter hysteresis:** from cnt=2, apply the following outcomes in sequence:
   - br=0 -> cnt=1, w_pr=0, w_ptgt=0x011.
   - br=1, br=1 -> cnt=3, saturated.
   - br=1 -> cnt stays 3.
   - br=0 -> cnt=2, w_pr=1.
   - w_nmis counts exactly the mispredicted updates.
4. **LRU replacement:** after reset, allocate 0x100, 0x104, 0x108, 0x10C (entries 0..3). Touch 0x100 (br=1). Allocate 0x110 -> it replaces 0x104. Then lookup 0x104 misses; 0x100, 0x108, 0x10C and 0x110 all hit.
5. **Flush with concurrent update:** with table full, assert w_flush and w_be (baddr=0x200) in the same cycle. Next cycle every lookup misses and w_nupd is unchanged. The next allocation lands in entry 0.
6. **Async reset mid-run:** pull w_rst_n low between edges while 0x010 is hit -> w_pre falls to 0 before the next edge and w_nupd/w_nmis read 0. After release, an update is accepted on the first edge.
